// File: rtl/ecdsa_verify_sequencer_pkg.sv
// Shared types for the ECDSA verification control path.
// verify_state_t : sequencer FSM states.
// mod_op_t       : operation select for the shared mod-n unit.
// Helpers classify FSM states so the top and any checker agree on them.
package elliptic_curve_structs;

    typedef enum logic [1:0] {
        MOD_INV   = 2'd0,
        MOD_MUL_E = 2'd1,
        MOD_MUL_R = 2'd2
    } mod_op_t;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        HASH = 4'd1,
        INV  = 4'd2,
        MUL1 = 4'd3,
        MUL2 = 4'd4,
        PM1  = 4'd5,
        PM2  = 4'd6,
        PADD = 4'd7,
        CMP  = 4'd8,
        DONE = 4'd9
    } verify_state_t;

    // True for states that wait on a datapath unit's done handshake.
    function automatic logic is_op_state(input verify_state_t s);
        logic r;
        case (s)
            HASH, INV, MUL1, MUL2, PM1, PM2, PADD: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    // Successor of an op state once its unit reports done.
    function automatic verify_state_t next_op_state(input verify_state_t s);
        verify_state_t r;
        case (s)
            HASH:    r = INV;
            INV:     r = MUL1;
            MUL1:    r = MUL2;
            MUL2:    r = PM1;
            PM1:     r = PM2;
            PM2:     r = PADD;
            PADD:    r = CMP;
            default: r = IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ecdsa_verify_sequencer_op.sv
// ecdsa_op_timer: watchdog for one datapath sub-operation.
// Ports: clk, reset (sync, active-high), clear (restart at 0),
//        enable (count this cycle), expired (count reached TIMEOUT_CYCLES).
module ecdsa_op_timer #(
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_r;

    // Cycle counter; saturates at the limit so expired stays asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && !expired) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/ecdsa_verify_sequencer.sv
// ecdsa_verify_sequencer: control FSM for full ECDSA verification.
// Sequences e=H(m); w=s^-1; u1=e*w; u2=r*w; P1=u1*G; P2=u2*Q; R=P1+P2;
// verdict = R not at infinity and x_R == r.
// Ports: init_verify/range_ok request; start_*/done_* handshakes with the
// hash, mod-n, point-multiply and point-add units; load_* latch strobes;
// mod_op/pmul_sel operand selects; busy, done_verify, sig_valid, timeout_err.
module ecdsa_verify_sequencer
    import elliptic_curve_structs::*;
#(
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    init_verify,
    input  logic    range_ok,
    output logic    start_hash,
    input  logic    done_hash,
    output logic    load_hash,
    output logic    start_mod,
    output mod_op_t mod_op,
    input  logic    done_mod,
    output logic    load_w,
    output logic    load_u1,
    output logic    load_u2,
    output logic    start_pmul,
    output logic    pmul_sel,
    input  logic    done_pmul,
    output logic    load_p1,
    output logic    load_p2,
    output logic    start_padd,
    input  logic    done_padd,
    input  logic    point_inf,
    input  logic    x_eq_r,
    output logic    busy,
    output logic    done_verify,
    output logic    sig_valid,
    output logic    timeout_err
);

    verify_state_t state_r;
    verify_state_t state_s;
    logic          first_r;       // first cycle in the current state
    logic          sig_valid_r;
    logic          timeout_err_r;
    logic          op_done_s;
    logic          expired_s;
    logic          timer_clear_s;

    // Select the done handshake that belongs to the current state.
    always_comb begin
        op_done_s = 1'b0;
        case (state_r)
            HASH:             op_done_s = done_hash;
            INV, MUL1, MUL2:  op_done_s = done_mod;
            PM1, PM2:         op_done_s = done_pmul;
            PADD:             op_done_s = done_padd;
            default:          op_done_s = 1'b0;
        endcase
    end

    // Next-state logic; a done arriving with the timeout wins.
    // A rejected request passes through CMP so every verdict takes at least
    // the compare cycle before DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (init_verify) begin
                    state_s = range_ok ? HASH : CMP;
                end else begin
                    state_s = IDLE;
                end
            end
            HASH, INV, MUL1, MUL2, PM1, PM2, PADD: begin
                if (op_done_s) begin
                    state_s = next_op_state(state_r);
                end else if (expired_s) begin
                    state_s = DONE;
                end else begin
                    state_s = state_r;
                end
            end
            CMP:     state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    assign timer_clear_s = (state_s != state_r);

    ecdsa_op_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_s),
        .enable (is_op_state(state_r)),
        .expired(expired_s)
    );

    // State register, first-cycle flag and held verdict flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            first_r       <= 1'b0;
            sig_valid_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            first_r <= (state_s != state_r);
            if (state_r == IDLE && init_verify) begin
                sig_valid_r   <= 1'b0;
                timeout_err_r <= 1'b0;
            end else if (state_r == PADD && done_padd) begin
                sig_valid_r   <= !point_inf && x_eq_r;
                timeout_err_r <= timeout_err_r;
            end else if (is_op_state(state_r) && !op_done_s && expired_s) begin
                sig_valid_r   <= 1'b0;
                timeout_err_r <= 1'b1;
            end else begin
                sig_valid_r   <= sig_valid_r;
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    // Operand selects follow the state and rest at their zero encoding.
    always_comb begin
        mod_op   = MOD_INV;
        pmul_sel = 1'b0;
        case (state_r)
            MUL1:    mod_op   = MOD_MUL_E;
            MUL2:    mod_op   = MOD_MUL_R;
            PM2:     pmul_sel = 1'b1;
            default: begin
                mod_op   = MOD_INV;
                pmul_sel = 1'b0;
            end
        endcase
    end

    assign start_hash  = first_r && (state_r == HASH);
    assign start_mod   = first_r && (state_r == INV || state_r == MUL1 || state_r == MUL2);
    assign start_pmul  = first_r && (state_r == PM1 || state_r == PM2);
    assign start_padd  = first_r && (state_r == PADD);

    // Load strobes coincide with the unit's done so the result is latched
    // in the same cycle it is presented.
    assign load_hash   = (state_r == HASH) && done_hash;
    assign load_w      = (state_r == INV)  && done_mod;
    assign load_u1     = (state_r == MUL1) && done_mod;
    assign load_u2     = (state_r == MUL2) && done_mod;
    assign load_p1     = (state_r == PM1)  && done_pmul;
    assign load_p2     = (state_r == PM2)  && done_pmul;

    assign busy        = (state_r != IDLE);
    assign done_verify = (state_r == DONE);
    assign sig_valid   = sig_valid_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_ecdsa_verify_sequencer.sv
// Self-checking bench for ecdsa_verify_sequencer (TIMEOUT_CYCLES = 8).
// A cycle-accurate responder answers each start with its done three cycles
// later; observed starts, loads and verdicts are compared to hand-computed
// values from a vector table plus a hand-written reset/held-init sequence.
module tb_ecdsa_verify_sequencer;
    import elliptic_curve_structs::*;

    logic    clk = 1'b0;
    logic    reset, init_verify, range_ok;
    logic    done_hash, done_mod, done_pmul, done_padd, point_inf, x_eq_r;
    logic    start_hash, load_hash, start_mod, load_w, load_u1, load_u2;
    logic    start_pmul, pmul_sel, load_p1, load_p2, start_padd;
    logic    busy, done_verify, sig_valid, timeout_err;
    mod_op_t mod_op;

    always #5 clk = ~clk;

    ecdsa_verify_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .init_verify(init_verify), .range_ok(range_ok),
        .start_hash(start_hash), .done_hash(done_hash), .load_hash(load_hash),
        .start_mod(start_mod), .mod_op(mod_op), .done_mod(done_mod),
        .load_w(load_w), .load_u1(load_u1), .load_u2(load_u2),
        .start_pmul(start_pmul), .pmul_sel(pmul_sel), .done_pmul(done_pmul),
        .load_p1(load_p1), .load_p2(load_p2), .start_padd(start_padd),
        .done_padd(done_padd), .point_inf(point_inf), .x_eq_r(x_eq_r),
        .busy(busy), .done_verify(done_verify), .sig_valid(sig_valid),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    int st_cyc[$];
    int st_kind[$];   // 0 hash, 1 mod, 2 pmul, 3 padd
    int st_aux[$];    // mod_op or pmul_sel at the start
    int n_loads, n_dv, dv_cycle;
    bit end_sig, end_terr, end_busy, busy_c1;

    typedef struct {
        bit rok; bit inf; bit xeq; bit stall;
        int n_starts; int n_loads; int dv_cycle; bit sig; bit terr;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({start_hash, load_hash, start_mod, mod_op, load_w, load_u1,
                     load_u2, start_pmul, pmul_sel, load_p1, load_p2, start_padd,
                     busy, done_verify, sig_valid, timeout_err});
    endfunction

    // Drives one request starting at cycle 0 and records what the DUT does.
    task automatic run(input bit rok, input bit inf, input bit xeq, input bit stall,
                       input bit hold, input int reset_at, input int ncyc);
        int  hs = -100, ms = -100, ps = -100, as_ = -100;
        bit  ps_sel = 1'b0;
        st_cyc.delete(); st_kind.delete(); st_aux.delete();
        n_loads = 0; n_dv = 0; dv_cycle = -1; busy_c1 = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            reset       = (reset_at >= 0) && (c >= reset_at) && (c < reset_at + 3);
            init_verify = (c == 0) || (hold && (reset_at < 0 || c < reset_at));
            range_ok    = rok;
            point_inf   = inf;
            x_eq_r      = xeq;
            done_hash   = (c == hs + 3);
            done_mod    = (c == ms + 3);
            done_pmul   = (c == ps + 3) && !(stall && !ps_sel);
            done_padd   = (c == as_ + 3);
            #4;
            if (start_hash) begin hs = c; st_cyc.push_back(c); st_kind.push_back(0); st_aux.push_back(0); end
            if (start_mod) begin ms = c; st_cyc.push_back(c); st_kind.push_back(1); st_aux.push_back(int'(mod_op)); end
            if (start_pmul) begin ps = c; ps_sel = pmul_sel; st_cyc.push_back(c); st_kind.push_back(2); st_aux.push_back(int'(pmul_sel)); end
            if (start_padd) begin as_ = c; st_cyc.push_back(c); st_kind.push_back(3); st_aux.push_back(0); end
            n_loads += int'(load_hash) + int'(load_w) + int'(load_u1) + int'(load_u2)
                     + int'(load_p1) + int'(load_p2);
            if (done_verify) begin n_dv++; dv_cycle = c; end
            if (c == 1) busy_c1 = busy;
            if (reset_at >= 0 && c > reset_at && c <= reset_at + 3)
                chk($sformatf("outputs_after_reset_c%0d", c), all_outs(), 0);
            end_sig  = sig_valid;
            end_terr = timeout_err;
            end_busy = busy;
            @(posedge clk);
            #1;
        end
        reset = 1'b0; init_verify = 1'b0;
        done_hash = 1'b0; done_mod = 1'b0; done_pmul = 1'b0; done_padd = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        int   exp_kind[7];
        int   exp_aux[7];
        int   n_h;
        exp_kind = '{0, 1, 1, 1, 2, 2, 3};
        exp_aux  = '{0, 0, 1, 2, 0, 1, 0};
        //          rok inf xeq stall nst nld  dv  sig terr
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 7, 6, 30, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 0,  2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 7, 6, 30, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 7, 6, 30, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 5, 4, 26, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 7, 6, 30, 1'b1, 1'b0};

        reset = 1'b1; init_verify = 1'b1; range_ok = 1'b1;
        done_hash = 1'b1; done_mod = 1'b1; done_pmul = 1'b1; done_padd = 1'b1;
        point_inf = 1'b0; x_eq_r = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", all_outs(), 0);
        reset = 1'b0; init_verify = 1'b0;
        done_hash = 1'b0; done_mod = 1'b0; done_pmul = 1'b0; done_padd = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            run(vecs[v].rok, vecs[v].inf, vecs[v].xeq, vecs[v].stall, 1'b0, -1, 36);
            chk($sformatf("v%0d_busy_c1", v), int'(busy_c1), 1);
            chk($sformatf("v%0d_n_starts", v), st_cyc.size(), vecs[v].n_starts);
            for (int i = 0; i < st_cyc.size() && i < vecs[v].n_starts; i++) begin
                chk($sformatf("v%0d_start%0d_cycle", v, i), st_cyc[i], 1 + 4 * i);
                chk($sformatf("v%0d_start%0d_unit_op", v, i),
                    st_kind[i] * 4 + st_aux[i], exp_kind[i] * 4 + exp_aux[i]);
            end
            chk($sformatf("v%0d_n_loads", v), n_loads, vecs[v].n_loads);
            chk($sformatf("v%0d_n_done_verify", v), n_dv, 1);
            chk($sformatf("v%0d_done_cycle", v), dv_cycle, vecs[v].dv_cycle);
            chk($sformatf("v%0d_sig_valid", v), int'(end_sig), int'(vecs[v].sig));
            chk($sformatf("v%0d_timeout_err", v), int'(end_terr), int'(vecs[v].terr));
            chk($sformatf("v%0d_idle_at_end", v), int'(end_busy), 0);
        end

        // init_verify held high, reset for 3 cycles while in PM2 (cycles 21..24).
        run(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 22, 26);
        n_h = 0;
        foreach (st_kind[i]) if (st_kind[i] == 0) n_h++;
        chk("held_init_single_hash_start", n_h, 1);
        chk("reset_run_n_starts", st_cyc.size(), 6);
        if (st_cyc.size() == 6) begin
            chk("reset_run_last_start_cycle", st_cyc[5], 21);
            chk("reset_run_last_start_pm2", st_kind[5] * 4 + st_aux[5], 9);
        end
        chk("reset_run_no_done_verify", n_dv, 0);

        // After the abort a fresh request must follow the nominal timing.
        run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, 36);
        chk("post_reset_n_starts", st_cyc.size(), 7);
        chk("post_reset_done_cycle", dv_cycle, 30);
        chk("post_reset_sig_valid", int'(end_sig), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
